// File: rtl/acc_handshake_responder_pkg.sv
// Shared types and defaults for the accelerator-side enable/done handshake responders.
// Also used by the CCD responder, so keep the state encoding stable.
package acc_handshake_responder_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BUSY  = 3'd2,
        ABORT = 3'd3,
        DONE  = 3'd4
    } acc_state_t;

    localparam int unsigned ACC_TIMEOUT_CYCLES_DEFAULT = 4096;
    localparam int unsigned ACC_CNT_W_DEFAULT          = 16;

    // Counter value seen in the last BUSY cycle before a timeout abort.
    function automatic logic [31:0] timeout_last(input int unsigned cycles);
        return (cycles == 0) ? 32'd0 : 32'(cycles - 1);
    endfunction

endpackage

// File: rtl/acc_handshake_responder_if.sv
// Enable/done handshake plus core sequencing signals between CPU status bits,
// the responder and the accelerator core.
interface acc_handshake_responder_if
    import acc_handshake_responder_pkg::*;
#(
    parameter int unsigned CNT_W = ACC_CNT_W_DEFAULT
) ();

    logic             iACC_en;
    logic             oACC_done;
    logic             oCore_start;
    logic             oCore_abort;
    logic             iCore_done;
    logic             oBusy;
    logic             oTimeout;
    logic [CNT_W-1:0] oCycles;

    // Responder side
    modport slave (
        input  iACC_en,
        input  iCore_done,
        output oACC_done,
        output oCore_start,
        output oCore_abort,
        output oBusy,
        output oTimeout,
        output oCycles
    );

    // CPU/core side
    modport master (
        output iACC_en,
        output iCore_done,
        input  oACC_done,
        input  oCore_start,
        input  oCore_abort,
        input  oBusy,
        input  oTimeout,
        input  oCycles
    );

endinterface

// File: rtl/acc_handshake_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; pins at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] q,
    output logic             at_max
);

    logic [CNT_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (clear) begin
            q_reg <= '0;
        end else if (inc && !at_max) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign at_max = &q_reg;
    assign q      = q_reg;

endmodule

// File: rtl/acc_handshake_responder.sv
// Accelerator end of the CPU enable/done four-phase handshake: starts the core,
// supervises it with a busy timeout and reports the busy-cycle count.
module acc_handshake_responder
    import acc_handshake_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ACC_TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = ACC_CNT_W_DEFAULT
) (
    input logic                      clk,
    input logic                      rst,
    acc_handshake_responder_if.slave bus
);

    localparam logic [31:0] TIMEOUT_LAST = timeout_last(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    acc_state_t       state_reg, state_next;
    logic             done_reg, start_reg, abort_reg, busy_reg, timeout_reg;
    logic             done_next, start_next, abort_next, busy_next, timeout_next;
    logic             cnt_clear, cnt_inc, cnt_at_max;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycles (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .q      (cnt_q),
        .at_max (cnt_at_max)
    );

    // Compared at 32 bits so a timeout beyond the counter range simply never fires.
    assign timeout_hit = TIMEOUT_EN && (32'(cnt_q) == TIMEOUT_LAST);
    assign cnt_inc     = (state_reg == BUSY) && !cnt_at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timeout_next = timeout_reg;
        cnt_clear    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.iACC_en) begin
                    state_next   = START;
                    cnt_clear    = 1'b1;
                    timeout_next = 1'b0;
                end
            end
            START: state_next = BUSY;
            BUSY: begin
                // Core completion beats both a CPU withdrawal and a timeout in the same cycle.
                if (bus.iCore_done) begin
                    state_next = DONE;
                end else if (!bus.iACC_en) begin
                    state_next = ABORT;
                end else if (timeout_hit) begin
                    state_next   = ABORT;
                    timeout_next = 1'b1;
                end
            end
            ABORT: state_next = bus.iACC_en ? DONE : IDLE;
            DONE: begin
                if (!bus.iACC_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        start_next = (state_next == START);
        busy_next  = (state_next == START) || (state_next == BUSY);
        abort_next = (state_next == ABORT);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg    <= 1'b0;
            start_reg   <= 1'b0;
            abort_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            done_reg    <= done_next;
            start_reg   <= start_next;
            abort_reg   <= abort_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.oACC_done   = done_reg;
    assign bus.oCore_start = start_reg;
    assign bus.oCore_abort = abort_reg;
    assign bus.oBusy       = busy_reg;
    assign bus.oTimeout    = timeout_reg;
    assign bus.oCycles     = cnt_q;

endmodule
